// File: rtl/p2s_shift_8.sv
// ---------------------------------------------------------------------------
// p2s_shift_8
//
// Parallel-to-serial shifter for a cascaded 164/595-style display chain.
// On an accepted start it captures the parallel word. It then clocks the word
// out one bit per 2*DIV clk cycles:
//   - sclk is low for DIV cycles, then high for DIV cycles.
//   - sdata only changes at the start of the low phase.
// After the last bit it raises slatch for DIV cycles. It then returns to idle
// with a one-cycle done pulse.
//
// Parameters
//   DATA_BITS  width of the parallel word (>= 1)
//   DIV        clk cycles per sclk half-period (>= 1)
//   MSB_FIRST  1: din[DATA_BITS-1] goes out first, 0: din[0] goes out first
//
// Ports
//   clk     in   system clock, rising-edge active
//   clear   in   asynchronous active-high reset
//   start   in   transfer request, only looked at while idle
//   din     in   parallel word, captured on the accepting edge
//   busy    out  transfer in progress
//   done    out  one-cycle pulse in the first idle cycle after a transfer
//   sdata   out  serial data
//   sclk    out  serial clock; the chain samples sdata on its rising edge
//   slatch  out  output-latch strobe for the chain
// ---------------------------------------------------------------------------
module p2s_shift_8 #(
  parameter int DATA_BITS = 8,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] din,
  output logic                 busy,
  output logic                 done,
  output logic                 sdata,
  output logic                 sclk,
  output logic                 slatch
);

  // Counter widths never drop to zero bits, even for DATA_BITS = 1 or DIV = 1.
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t               state_reg,  state_next;
  logic [DATA_BITS-1:0] shreg_reg,  shreg_next;
  logic [BW-1:0]        bitcnt_reg, bitcnt_next;
  logic [PW-1:0]        phase_reg,  phase_next;

  // All outputs are registered, so that sclk and slatch come straight from
  // flops. That keeps them glitch-free on the external chain.
  logic busy_reg,   busy_next;
  logic done_reg,   done_next;
  logic sdata_reg,  sdata_next;
  logic sclk_reg,   sclk_next;
  logic slatch_reg, slatch_next;

  logic                 phase_end;
  logic [DATA_BITS-1:0] shreg_adv;   // register moved one place toward the head
  logic                 head_next;   // bit that sits at the head after this edge

  assign phase_end = (phase_reg == PH_LAST);

  // The head is the MSB or the LSB. Advancing moves the next bit into the head.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_adv = shreg_reg << 1;
      assign head_next = shreg_next[DATA_BITS-1];
    end else begin : g_lsb_first
      assign shreg_adv = shreg_reg >> 1;
      assign head_next = shreg_next[0];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State register and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      phase_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sdata_reg  <= 1'b0;
      sclk_reg   <= 1'b0;
      slatch_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      bitcnt_reg <= bitcnt_next;
      phase_reg  <= phase_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      sdata_reg  <= sdata_next;
      sclk_reg   <= sclk_next;
      slatch_reg <= slatch_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    phase_next  = phase_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_next  = din;
          bitcnt_next = BIT_LAST;
          phase_next  = '0;
          state_next  = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (phase_end) begin
          phase_next = '0;
          state_next = SHIFT_HI;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          phase_next = '0;
          if (bitcnt_reg == '0) begin
            // Last bit done. The head keeps that bit, so sdata holds it
            // through the latch phase.
            state_next = LATCH;
          end else begin
            // Advance only here. The new head bit therefore appears together
            // with sclk going low.
            shreg_next  = shreg_adv;
            bitcnt_next = bitcnt_reg - BW'(1);
            state_next  = SHIFT_LO;
          end
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end

      LATCH: begin
        if (phase_end) begin
          phase_next = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode. These signals are taken from the next state, so that the
  // registered outputs line up with the state they describe.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_next   = (state_next != IDLE);
    sclk_next   = (state_next == SHIFT_HI);
    slatch_next = (state_next == LATCH);
    // sdata is forced low while idle, so the line rests at 0 between transfers.
    sdata_next  = (state_next != IDLE) && head_next;
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign sdata  = sdata_reg;
  assign sclk   = sclk_reg;
  assign slatch = slatch_reg;

endmodule
